addsub_rr_arbiter: RTL and testbench



---
 rtl/addsub_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_addsub_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter
// Shares one N-bit add/subtract datapath among R requesters. A round-robin
// arbiter picks one valid requester per accepted operation. The result goes
// into a single registered response slot that has valid/ready backpressure.
// The slot is reloaded in the same cycle it is drained, so the unit sustains
// one operation per cycle.
//
// Optional feature: define ADDSUB_RR_ARBITER_STATS_EN to add the 16-bit
// saturating output stat_sovf_count. It counts accepted operations whose
// signed result overflowed.

module addsub_rr_arbiter #(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  input  logic [R-1:0]     req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_uovf,
  output logic             rsp_sovf,
  output logic [IDW-1:0]   rsp_id
`ifdef ADDSUB_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]      stat_sovf_count
`endif
);

  // Response slot occupancy. These are the only two states.
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  localparam logic [IDW-1:0] LAST_ID = IDW'(R - 1);

  logic             state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]     result_q, result_d;
  logic             uovf_q, uovf_d;
  logic             sovf_q, sovf_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             can_accept;
  logic             accept;

  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             op_sub;

  logic [N:0]       sum_ext;
  logic [N-1:0]     diff;
  logic [N-1:0]     calc_result;
  logic             calc_uovf;
  logic             calc_sovf;

  // Round-robin search: p, p+1, ..., R-1, 0, ... The first valid requester wins.
  always_comb begin
    // NOTE: every variable assigned in an always_comb block gets a default
    // first. Otherwise a path that skips the assignment infers a latch.
    int             cand;
    logic [IDW-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < R; off++) begin
      cand     = (int'(ptr_q) + off) % R;
      cand_idx = IDW'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Accept when the slot is free or is being drained this cycle. Reset masks it.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || rsp_ready;
    accept     = grant_found && can_accept && !rst;
    req_ready  = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Route the granted requester's operands and opcode to the shared datapath.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (grant_idx == IDW'(i)) begin
        op_a   = req_a[i*N +: N];
        op_b   = req_b[i*N +: N];
        op_sub = req_op[i];
      end
    end
  end

  // Shared add/subtract with unsigned carry/borrow and signed overflow flags.
  always_comb begin
    sum_ext = {1'b0, op_a} + {1'b0, op_b};
    diff    = op_a - op_b;
    if (op_sub) begin
      calc_result = diff;
      calc_uovf   = (op_a < op_b);
      calc_sovf   = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
    end else begin
      calc_result = sum_ext[N-1:0];
      calc_uovf   = sum_ext[N];
      calc_sovf   = (op_a[N-1] == op_b[N-1]) && (sum_ext[N-1] != op_a[N-1]);
    end
  end

  // Next-state: load on accept, drain to EMPTY when consumed without a refill.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    uovf_d   = uovf_q;
    sovf_d   = sovf_q;
    id_d     = id_q;
    if (accept) begin
      state_d  = ST_FULL;
      result_d = calc_result;
      uovf_d   = calc_uovf;
      sovf_d   = calc_sovf;
      id_d     = grant_idx;
      ptr_d    = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State and response registers. Asynchronous reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all control and output registers are reset here because they are
    // architecturally visible right after reset. Sequential state uses
    // non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      result_q <= '0;
      uovf_q   <= 1'b0;
      sovf_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      uovf_q   <= uovf_d;
      sovf_q   <= sovf_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_result = result_q;
  assign rsp_uovf   = uovf_q;
  assign rsp_sovf   = sovf_q;
  assign rsp_id     = id_q;

`ifdef ADDSUB_RR_ARBITER_STATS_EN
  logic [15:0] stat_q, stat_d;

  // Saturating count of accepted operations whose signed result overflowed.
  always_comb begin
    stat_d = stat_q;
    if (accept && calc_sovf && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  // Statistics register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_sovf_count = stat_q;
`endif

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Testbench for addsub_rr_arbiter. The driver issues requests and predicts
// grants from a behavioural round-robin model. Each predicted response is
// pushed into a queue. A separate monitor pops the queue whenever the DUT
// hands a response over.

module tb_addsub_rr_arbiter;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int IDW = 2;

  typedef struct {
    int result;
    int uovf;
    int sovf;
    int id;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R*N-1:0]   req_a;
  logic [R*N-1:0]   req_b;
  logic [R-1:0]     req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic             rsp_uovf;
  logic             rsp_sovf;
  logic [IDW-1:0]   rsp_id;
`ifdef ADDSUB_RR_ARBITER_STATS_EN
  logic [15:0]      stat_sovf_count;
`endif

  addsub_rr_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_uovf   (rsp_uovf),
    .rsp_sovf   (rsp_sovf),
    .rsp_id     (rsp_id)
`ifdef ADDSUB_RR_ARBITER_STATS_EN
    ,
    .stat_sovf_count (stat_sovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  exp_t model_q[$];
  bit   model_full = 1'b0;
  int   model_ptr  = 0;
  bit   pend[R];
  int   pa[R];
  int   pb[R];
  bit   psub[R];
  int   last_ready = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Spec arithmetic in plain integers: modular result, carry/borrow and signed range.
  function automatic exp_t model(input int a, input int b, input bit sub, input int id);
    exp_t e;
    int full, sa, sb, s;
    full     = sub ? a - b : a + b;
    e.result = (full + (1 << N)) % (1 << N);
    e.uovf   = sub ? int'(a < b) : int'(full >= (1 << N));
    sa       = (a >= (1 << (N-1))) ? a - (1 << N) : a;
    sb       = (b >= (1 << (N-1))) ? b - (1 << N) : b;
    s        = sub ? sa - sb : sa + sb;
    e.sovf   = int'((s > (1 << (N-1)) - 1) || (s < -(1 << (N-1))));
    e.id     = id;
    return e;
  endfunction

  task automatic post(input int i, input int a, input int b, input bit sub);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    psub[i] = sub;
  endtask

  // One clock cycle: drive inputs, predict and check the grant, update the model.
  task automatic cycle(input bit rr);
    int  g;
    int  idx;
    bit  can;
    @(negedge clk);
    for (int i = 0; i < R; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*N +: N]    = N'(pa[i]);
      req_b[i*N +: N]    = N'(pb[i]);
      req_op[i]          = psub[i];
    end
    rsp_ready = rr;
    #1;
    can = !model_full || rr;
    g   = -1;
    if (can) begin
      for (int k = 0; k < R; k++) begin
        idx = (model_ptr + k) % R;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    last_ready = int'(req_ready);
    check("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
    if (g >= 0) begin
      model_q.push_back(model(pa[g], pb[g], psub[g], g));
      model_ptr = (g + 1) % R;
      pend[g]   = 1'b0;
    end
    @(posedge clk);
    model_full = (g >= 0) || (model_full && !rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_result", int'(rsp_result), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_flags", int'({rsp_uovf, rsp_sovf}), 0);
    model_q.delete();
    model_full = 1'b0;
    model_ptr  = 0;
    for (int i = 0; i < R; i++) pend[i] = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: check occupancy, stability under backpressure, and consumed responses.
  bit            hold_prev = 1'b0;
  logic [N-1:0]  h_result;
  logic          h_uovf, h_sovf;
  logic [IDW-1:0] h_id;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("rsp_valid", int'(rsp_valid), int'(model_full));
      if (hold_prev && rsp_valid) begin
        check("hold_result", int'(rsp_result), int'(h_result));
        check("hold_id", int'(rsp_id), int'(h_id));
        check("hold_flags", int'({rsp_uovf, rsp_sovf}), int'({h_uovf, h_sovf}));
      end
      if (rsp_valid && rsp_ready) begin
        if (model_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = model_q.pop_front();
          check("rsp_result", int'(rsp_result), e.result);
          check("rsp_uovf", int'(rsp_uovf), e.uovf);
          check("rsp_sovf", int'(rsp_sovf), e.sovf);
          check("rsp_id", int'(rsp_id), e.id);
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      h_result  = rsp_result;
      h_uovf    = rsp_uovf;
      h_sovf    = rsp_sovf;
      h_id      = rsp_id;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < R; i++) begin
      pend[i] = 1'b0; pa[i] = 0; pb[i] = 0; psub[i] = 1'b0;
    end

    // Reset state
    @(negedge clk);
    #1;
    check("init_rsp_valid", int'(rsp_valid), 0);
    check("init_req_ready", int'(req_ready), 0);
    check("init_rsp_result", int'(rsp_result), 0);
    check("init_rsp_id", int'(rsp_id), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, add: 7+1 from requester 2
    post(2, 7, 1, 1'b0);
    cycle(1'b1);
    check("add_req_ready", last_ready, 4);
    #1;
    check("add_result", int'(rsp_result), 8);
    check("add_uovf", int'(rsp_uovf), 0);
    check("add_sovf", int'(rsp_sovf), 1);
    check("add_id", int'(rsp_id), 2);

    // Single request, sub: 3-5 from requester 0
    post(0, 3, 5, 1'b1);
    cycle(1'b1);
    #1;
    check("sub_result", int'(rsp_result), 14);
    check("sub_uovf", int'(rsp_uovf), 1);
    check("sub_sovf", int'(rsp_sovf), 0);
    check("sub_id", int'(rsp_id), 0);

    // Mid-operation reset with a response held and a request pending
    post(1, 2, 2, 1'b0);
    do_reset();
    post(3, 9, 4, 1'b1);
    cycle(1'b1);
    check("post_rst_grant", last_ready, 8);

    // Round-robin: all requesters valid for 8 cycles
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < R; i++)
        if (!pend[i]) post(i, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
      cycle(1'b1);
      check("rr_grant", last_ready, 1 << (k % R));
    end
    for (int i = 0; i < R; i++) pend[i] = 1'b0;

    // Backpressure: slot full, requesters 1 and 3 wait
    post(1, 5, 6, 1'b0);
    post(3, 12, 3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0);
      check("bp_req_ready", last_ready, 0);
    end
    cycle(1'b1);
    check("bp_release_grant", last_ready, 2);
    cycle(1'b1);
    check("bp_second_grant", last_ready, 8);
    cycle(1'b1);

`ifdef ADDSUB_RR_ARBITER_STATS_EN
    // Stats: 7+7, 8-1, 1+1, 8+8 -> three signed overflows
    do_reset();
    post(0, 7, 7, 1'b0); cycle(1'b1);
    post(0, 8, 1, 1'b1); cycle(1'b1);
    post(0, 1, 1, 1'b0); cycle(1'b1);
    post(0, 8, 8, 1'b0); cycle(1'b1);
    #1;
    check("stat_sovf_count", int'(stat_sovf_count), 3);
`endif

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < R; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1)
          post(i, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
      cycle($urandom_range(3, 0) != 0);
    end

    // Drain everything, bounded
    for (int k = 0; k < 64; k++) begin
      bit busy;
      busy = model_full;
      for (int i = 0; i < R; i++) busy = busy | pend[i];
      if (!busy) break;
      cycle(1'b1);
    end
    cycle(1'b1);
    #3;
    check("drain_rsp_valid", int'(rsp_valid), 0);
    check("drain_queue_empty", model_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
